// File: rtl/rm_lane_ctrl_if.sv
// Allocation and release handshake bundle for rm_lane_ctrl.
// The requester uses the master modport; the controller uses the slave modport.
interface rm_lane_ctrl_if #(
  parameter  int unsigned NUM_LANES = 5,
  localparam int unsigned LANE_ID_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
);
  logic                 alloc_valid_i;
  logic                 alloc_ready_o;
  logic [LANE_ID_W-1:0] alloc_lane_o;
  logic                 rel_valid_i;
  logic [LANE_ID_W-1:0] rel_lane_i;

  modport master (
    output alloc_valid_i,
    input  alloc_ready_o,
    input  alloc_lane_o,
    output rel_valid_i,
    output rel_lane_i
  );

  modport slave (
    input  alloc_valid_i,
    output alloc_ready_o,
    output alloc_lane_o,
    input  rel_valid_i,
    input  rel_lane_i
  );
endinterface

// File: rtl/rm_lane_ctrl.sv
// Lane allocation controller: grants free monitor lanes, clears them for one cycle, tracks releases.
// Optional per-lane idle watchdog reclaim is built when RM_LANE_WDOG_EN is defined.
module rm_lane_ctrl #(
  parameter  int unsigned NUM_LANES = 5,
  parameter  int unsigned WDOG_W    = 8,
  localparam int unsigned LANE_ID_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  rm_lane_ctrl_if.slave        bus,
  input  logic [NUM_LANES-1:0] lane_active_i,
  input  logic [WDOG_W-1:0]    wdog_limit_i,
  output logic [NUM_LANES-1:0] lane_reset_o,
  output logic [NUM_LANES-1:0] lane_busy_o,
  output logic [NUM_LANES-1:0] wdog_expired_o
);

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    CLEAR = 2'd1,
    BUSY  = 2'd2
  } lane_state_e;

  lane_state_e          state_q [NUM_LANES];
  lane_state_e          state_d [NUM_LANES];
  logic                 init_done_q;
  logic                 any_free;
  logic                 ready;
  logic [LANE_ID_W-1:0] free_lane;
  logic [NUM_LANES-1:0] grant;
  logic [NUM_LANES-1:0] rel_hit;
  logic [NUM_LANES-1:0] expire;
  logic [NUM_LANES-1:0] reset_d;
  logic [NUM_LANES-1:0] busy_d;
  logic [NUM_LANES-1:0] expired_d;

  // Priority pick of the lowest-index free lane; depends on registered state only.
  always_comb begin
    any_free  = 1'b0;
    free_lane = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (!any_free && state_q[i] == FREE) begin
        any_free  = 1'b1;
        free_lane = LANE_ID_W'(i);
      end
    end
  end

  assign ready             = init_done_q & any_free;
  assign bus.alloc_ready_o = ready;
  assign bus.alloc_lane_o  = free_lane;

  always_comb begin
    grant   = '0;
    rel_hit = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      grant[i]   = bus.alloc_valid_i & ready & (free_lane == LANE_ID_W'(i));
      rel_hit[i] = bus.rel_valid_i & (bus.rel_lane_i == LANE_ID_W'(i))
                   & (state_q[i] == BUSY);
    end
  end

`ifdef RM_LANE_WDOG_EN
  logic [WDOG_W-1:0] wcnt_q [NUM_LANES];
  logic [WDOG_W-1:0] wcnt_d [NUM_LANES];

  always_comb begin
    expire = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      expire[i] = (state_q[i] == BUSY) && (wdog_limit_i != '0)
                  && !lane_active_i[i] && (wcnt_q[i] == wdog_limit_i);
      if (state_q[i] != BUSY || lane_active_i[i]) begin
        wcnt_d[i] = '0;
      end else if (wcnt_q[i] == '1) begin
        wcnt_d[i] = wcnt_q[i];
      end else begin
        wcnt_d[i] = wcnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) wcnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_LANES; i++) wcnt_q[i] <= wcnt_d[i];
    end
  end
`else
  logic unused_wdog_inputs;
  assign unused_wdog_inputs = ^{lane_active_i, wdog_limit_i};
  assign expire             = '0;
`endif

  // Release takes priority over expiry, so a colliding expiry never pulses.
  always_comb begin
    reset_d   = '0;
    busy_d    = '0;
    expired_d = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        FREE:  if (grant[i]) state_d[i] = CLEAR;
        CLEAR: state_d[i] = BUSY;
        BUSY: begin
          if (rel_hit[i]) begin
            state_d[i] = FREE;
          end else if (expire[i]) begin
            state_d[i]   = FREE;
            expired_d[i] = 1'b1;
          end
        end
        default: state_d[i] = FREE;
      endcase
      reset_d[i] = (state_d[i] == CLEAR);
      busy_d[i]  = (state_d[i] != FREE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) state_q[i] <= FREE;
      init_done_q    <= 1'b0;
      lane_reset_o   <= '0;
      lane_busy_o    <= '0;
      wdog_expired_o <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_LANES; i++) state_q[i] <= state_d[i];
      init_done_q    <= 1'b1;
      lane_reset_o   <= reset_d;
      lane_busy_o    <= busy_d;
      wdog_expired_o <= expired_d;
    end
  end

endmodule
